// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Main control FSM of the multi-cycle RV32I core. Sequences
// fetch/decode/execute/memory/writeback over the shared ALU, memory port and
// immediate extender. It owns the memory request/ack handshake and detects
// illegal instructions and bus timeouts.
//
// Parameters
//   TRAP_ON_ILLEGAL  1: illegal opcode halts in S_ERR until reset
//                    0: one-cycle illegal_instr pulse, then the next fetch
//   MEM_TIMEOUT      number of unacknowledged mem_req cycles before
//                    bus_error; 0 disables the timeout
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   opcode, funct3   instruction fields from the IR (stable after fetch)
//   alu_zero/lt/ltu  ALU flags used to resolve branches
//   mem_ack          memory completes the current request this cycle
//   mem_req, mem_we  memory request (held until mem_ack) and write qualifier
//   adr_src          memory address select: 0 = PC, 1 = ALUOut
//   ir_write         latch instruction and old PC
//   pc_write         load PC from the result bus
//   reg_write        register file write of the result bus
//   alu_src_a        00 PC, 01 oldPC, 10 rs1, 11 zero
//   alu_src_b        00 rs2, 01 imm, 10 const 4
//   alu_op           00 add, 01 compare/sub, 10 funct-decoded
//   result_src       00 ALUOut, 01 memory data, 10 ALU result direct
//   imm_src          000 I, 001 S, 010 B, 011 U, 100 J (from opcode only)
//   illegal_instr    illegal-instruction indication (see TRAP_ON_ILLEGAL)
//   bus_error        memory timeout, sticky until reset
//   instr_retired    one-cycle pulse in the first fetch cycle after a
//                    retiring instruction
//
// The handshake and datapath controls are decoded from the state register so
// that the mem_ack and branch-flag dependent strobes act in the same cycle;
// the status flags are registered.
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int unsigned TRAP_ON_ILLEGAL = 1,
    parameter int unsigned MEM_TIMEOUT     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic       instr_retired
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_CYC = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JALR,
        S_JAL,
        S_LUI,
        S_AUIPC,
        S_ERR
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] wait_cnt;
    logic             in_mem;
    logic             timeout_hit;
    logic             decode_illegal;
    logic             taken;

    // States that hold mem_req and are therefore subject to the timeout
    assign in_mem = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

    // Timeout fires on the MEM_TIMEOUT-th unacknowledged cycle; an ack that
    // cycle takes priority
    assign timeout_hit = (MEM_TIMEOUT != 0) && in_mem && !mem_ack &&
                         ((wait_cnt + CNT_ONE) == TIMEOUT_CYC);

    // Branch condition from funct3
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = alu_zero;
            3'b001:  taken = !alu_zero;
            3'b100:  taken = alu_lt;
            3'b101:  taken = !alu_lt;
            3'b110:  taken = alu_ltu;
            3'b111:  taken = !alu_ltu;
            default: taken = 1'b0;
        endcase
    end

    // Extender select depends on the opcode alone
    always_comb begin
        imm_src = 3'b000;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: imm_src = 3'b000;
            OP_STORE:                 imm_src = 3'b001;
            OP_BRANCH:                imm_src = 3'b010;
            OP_LUI, OP_AUIPC:         imm_src = 3'b011;
            OP_JAL:                   imm_src = 3'b100;
            default:                  imm_src = 3'b000;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nx       = state;
        decode_illegal = 1'b0;
        case (state)
            S_RESET:  state_nx = S_FETCH;
            S_FETCH:  if (mem_ack) state_nx = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_nx = S_MEMADR;
                    OP_REG:            state_nx = S_EXECR;
                    OP_IMM:            state_nx = S_EXECI;
                    OP_BRANCH: begin
                        if (funct3 == 3'b010 || funct3 == 3'b011) decode_illegal = 1'b1;
                        else state_nx = S_BRANCH;
                    end
                    OP_JAL:            state_nx = S_JAL;
                    OP_JALR: begin
                        if (funct3 != 3'b000) decode_illegal = 1'b1;
                        else state_nx = S_JALR;
                    end
                    OP_LUI:            state_nx = S_LUI;
                    OP_AUIPC:          state_nx = S_AUIPC;
                    OP_FENCE:          state_nx = S_FETCH;
                    default:           decode_illegal = 1'b1;
                endcase
                if (decode_illegal) state_nx = (TRAP_ON_ILLEGAL != 0) ? S_ERR : S_FETCH;
            end
            S_MEMADR: state_nx = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ack) state_nx = S_MEMWB;
            S_MEMWB:  state_nx = S_FETCH;
            S_MEMWR:  if (mem_ack) state_nx = S_FETCH;
            S_EXECR:  state_nx = S_ALUWB;
            S_EXECI:  state_nx = S_ALUWB;
            S_ALUWB:  state_nx = S_FETCH;
            S_BRANCH: state_nx = S_FETCH;
            S_JALR:   state_nx = S_JAL;
            S_JAL:    state_nx = S_ALUWB;
            S_LUI:    state_nx = S_ALUWB;
            S_AUIPC:  state_nx = S_ALUWB;
            S_ERR:    state_nx = S_ERR;
            default:  state_nx = S_ERR;
        endcase
        if (timeout_hit) state_nx = S_ERR;
    end

    // Control decode per state; anything not listed stays 0
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = taken;
            end
            S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            // PC <= ALUOut (target) while the ALU forms the link value oldPC+4
            S_JAL: begin
                pc_write  = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            default: ;
        endcase
    end

    // State register, wait counter and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_RESET;
            wait_cnt      <= '0;
            bus_error     <= 1'b0;
            illegal_instr <= 1'b0;
            instr_retired <= 1'b0;
        end else begin
            state <= state_nx;
            // Counts unacknowledged request cycles; zero on entry and after ack
            if (in_mem && !mem_ack) wait_cnt <= wait_cnt + CNT_ONE;
            else                    wait_cnt <= '0;
            if (timeout_hit) bus_error <= 1'b1;
            // Trapping mode holds the flag in S_ERR; otherwise it is a pulse
            illegal_instr <= decode_illegal || (illegal_instr && (TRAP_ON_ILLEGAL != 0));
            instr_retired <= (state_nx == S_FETCH) && (state != S_FETCH) &&
                             (state != S_RESET) && !decode_illegal;
        end
    end

endmodule
